// File: rtl/sysarray_mxn.sv
// sysarray_mxn: ROWS x COLS output-stationary systolic matrix multiplier.
// Computes C = A*B (A: ROWS x K, B: K x COLS) with run-time K.
// Ports: clk, rst (async, active-high); start/k_len/busy job control;
//   in_valid/in_ready with a_col (one A column) and b_row (one B row);
//   out_valid/out_ready with out_row (one C row) and out_row_idx.
// Build option: define SYSARRAY_SAT_EN for saturating accumulation;
//   by default the accumulators wrap modulo 2^ACC_W.
module sysarray_mxn #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 24,
    parameter int K_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*A_W-1:0]     a_col,
    input  logic [COLS*B_W-1:0]     b_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*ACC_W-1:0]   out_row,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx
);

    localparam int RI_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int P_W  = A_W + B_W;
    localparam int FL   = ROWS + COLS - 2;
    localparam int FW   = $clog2(ROWS + COLS) + 1;
    localparam int CW   = (K_W > FW) ? K_W : FW;

    typedef enum logic [2:0] {
        IDLE, CLEAR, FEED, FLUSH, DRAIN
    } state_t;

    state_t          state, nxt;
    logic [K_W-1:0]  k_q;
    logic [CW-1:0]   cnt;
    logic [RI_W-1:0] ridx;
    logic            feed, clr, step, last_k, last_fl;

    logic [A_W-1:0]   ska    [ROWS][ROWS];
    logic [B_W-1:0]   skb    [COLS][COLS];
    logic [A_W-1:0]   a_edge [ROWS];
    logic [B_W-1:0]   b_edge [COLS];
    logic [A_W-1:0]   a_in   [ROWS][COLS];
    logic [B_W-1:0]   b_in   [ROWS][COLS];
    logic [A_W-1:0]   a_r    [ROWS][COLS];
    logic [B_W-1:0]   b_r    [ROWS][COLS];
    logic [ACC_W-1:0] acc    [ROWS][COLS];

    function automatic logic [ACC_W-1:0] mac(
        input logic [ACC_W-1:0] acc_v,
        input logic [A_W-1:0]   a_v,
        input logic [B_W-1:0]   b_v
    );
        logic signed [P_W-1:0]   ax, bx, p;
        logic signed [ACC_W-1:0] pe;
`ifdef SYSARRAY_SAT_EN
        logic signed [ACC_W:0]   s;
`endif
        ax = P_W'($signed(a_v));
        bx = P_W'($signed(b_v));
        p  = ax * bx;
        pe = ACC_W'(p);
`ifdef SYSARRAY_SAT_EN
        s = (ACC_W+1)'($signed(acc_v)) + (ACC_W+1)'(pe);
        // Top two bits disagree: the sum left the ACC_W range.
        if (s[ACC_W] != s[ACC_W-1])
            mac = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
        else
            mac = s[ACC_W-1:0];
`else
        mac = acc_v + pe;
`endif
    endfunction

    assign feed    = (state == FEED);
    assign clr     = (state == CLEAR);
    assign step    = (feed && in_valid) || (state == FLUSH);
    assign last_k  = feed && in_valid && (cnt == CW'(k_q) - CW'(1));
    assign last_fl = (state == FLUSH) && (cnt == CW'(FL - 1));

    // Edge injection: real data while feeding, zeros while flushing.
    for (genvar i = 0; i < ROWS; i++) begin : g_ae
        assign a_edge[i] = feed ? a_col[i*A_W +: A_W] : '0;
    end
    for (genvar j = 0; j < COLS; j++) begin : g_be
        assign b_edge[j] = feed ? b_row[j*B_W +: B_W] : '0;
    end

    // Row i taps its skew line at depth i; column j at depth j.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            if (j == 0) begin : g_al
                if (i == 0) begin : g_d0
                    assign a_in[i][j] = a_edge[i];
                end else begin : g_dn
                    assign a_in[i][j] = ska[i][i-1];
                end
            end else begin : g_ar
                assign a_in[i][j] = a_r[i][j-1];
            end
            if (i == 0) begin : g_bt
                if (j == 0) begin : g_d0
                    assign b_in[i][j] = b_edge[j];
                end else begin : g_dn
                    assign b_in[i][j] = skb[j][j-1];
                end
            end else begin : g_bd
                assign b_in[i][j] = b_r[i-1][j];
            end
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (start) nxt = CLEAR;
            CLEAR: nxt = (k_q != '0) ? FEED
                       : ((FL > 0) ? FLUSH : DRAIN);
            FEED:  if (last_k) nxt = (FL > 0) ? FLUSH : DRAIN;
            FLUSH: if (last_fl) nxt = DRAIN;
            DRAIN: if (out_ready && ridx == RI_W'(ROWS - 1))
                       nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k_q       <= '0;
            cnt       <= '0;
            ridx      <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= nxt;
            busy      <= (nxt != IDLE);
            in_ready  <= (nxt == FEED);
            out_valid <= (nxt == DRAIN);
            if (state == IDLE && start)
                k_q <= k_len;
            // One counter serves both FEED beats and FLUSH steps.
            if (state != nxt)
                cnt <= '0;
            else if (step)
                cnt <= cnt + CW'(1);
            if (state == DRAIN && out_ready)
                ridx <= (ridx == RI_W'(ROWS - 1)) ? '0
                                                  : ridx + RI_W'(1);
        end
    end

    // Whole array, skew lines included, moves only on a step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++)
                for (int d = 0; d < ROWS; d++)
                    ska[i][d] <= '0;
            for (int j = 0; j < COLS; j++)
                for (int d = 0; d < COLS; d++)
                    skb[j][d] <= '0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_r[i][j] <= '0;
                    b_r[i][j] <= '0;
                    acc[i][j] <= '0;
                end
        end else if (clr || step) begin
            for (int i = 0; i < ROWS; i++) begin
                ska[i][0] <= clr ? '0 : a_edge[i];
                for (int d = 1; d < ROWS; d++)
                    ska[i][d] <= clr ? '0 : ska[i][d-1];
            end
            for (int j = 0; j < COLS; j++) begin
                skb[j][0] <= clr ? '0 : b_edge[j];
                for (int d = 1; d < COLS; d++)
                    skb[j][d] <= clr ? '0 : skb[j][d-1];
            end
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_r[i][j] <= clr ? '0 : a_in[i][j];
                    b_r[i][j] <= clr ? '0 : b_in[i][j];
                    acc[i][j] <= clr ? '0
                               : mac(acc[i][j], a_in[i][j], b_in[i][j]);
                end
        end
    end

    always_comb begin
        out_row = '0;
        if (out_valid)
            for (int j = 0; j < COLS; j++)
                out_row[j*ACC_W +: ACC_W] = acc[ridx][j];
    end

    assign out_row_idx = ridx;

endmodule

// File: tb/tb_sysarray_mxn.sv
// tb_sysarray_mxn: scoreboard bench for sysarray_mxn.
// Two instances (ACC_W 24 and 16) share stimulus; rows checked vs a matrix model.
module tb_sysarray_mxn;

    localparam int R    = 4;
    localparam int C    = 4;
    localparam int AW   = 8;
    localparam int BW   = 8;
    localparam int KW   = 8;
    localparam int W1   = 24;
    localparam int W2   = 16;
    localparam int RIW  = 2;
    localparam int MAXK = 16;

    logic            clk = 1'b0;
    logic            rst, start, in_valid, out_ready;
    logic [KW-1:0]   k_len;
    logic [R*AW-1:0] a_col;
    logic [C*BW-1:0] b_row;
    logic            busy, in_ready, out_valid;
    logic            busy2, in_ready2, out_valid2;
    logic [C*W1-1:0] out_row;
    logic [C*W2-1:0] out_row2;
    logic [RIW-1:0]  ridx, ridx2;

    sysarray_mxn #(
        .ROWS(R), .COLS(C), .A_W(AW), .B_W(BW), .ACC_W(W1), .K_W(KW)
    ) u1 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_row_idx(ridx)
    );

    sysarray_mxn #(
        .ROWS(R), .COLS(C), .A_W(AW), .B_W(BW), .ACC_W(W2), .K_W(KW)
    ) u2 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy2), .in_valid(in_valid), .in_ready(in_ready2),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid2),
        .out_ready(out_ready), .out_row(out_row2), .out_row_idx(ridx2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [C*W1-1:0] r1;
        logic [C*W2-1:0] r2;
        logic [RIW-1:0]  idx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   A [R][MAXK];
    int   B [MAXK][C];

    task automatic check(input string nm,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic longint fold(longint a, longint p, int w);
        longint s, m;
        s = a + p;
        m = longint'(1) <<< w;
`ifdef SYSARRAY_SAT_EN
        if (s > m / 2 - 1) s = m / 2 - 1;
        if (s < -(m / 2)) s = -(m / 2);
`else
        s = s % m;
        if (s >= m / 2) s = s - m;
        if (s < -(m / 2)) s = s + m;
`endif
        return s;
    endfunction

    // mode 0: random, 1: identity A with B = 1..16, 2: all -128
    task automatic gen(input int mode, input int kk);
        for (int i = 0; i < R; i++)
            for (int k = 0; k < kk; k++)
                unique case (mode)
                    1: A[i][k] = (i == k) ? 1 : 0;
                    2: A[i][k] = -128;
                    default: A[i][k] = int'($urandom_range(0, 255)) - 128;
                endcase
        for (int k = 0; k < kk; k++)
            for (int j = 0; j < C; j++)
                unique case (mode)
                    1: B[k][j] = k * C + j + 1;
                    2: B[k][j] = -128;
                    default: B[k][j] = int'($urandom_range(0, 255)) - 128;
                endcase
    endtask

    task automatic push_expected(input int kk);
        exp_t   e;
        longint s1, s2, p;
        for (int r = 0; r < R; r++) begin
            e = '0;
            for (int j = 0; j < C; j++) begin
                s1 = 0;
                s2 = 0;
                for (int k = 0; k < kk; k++) begin
                    p  = longint'(A[r][k]) * longint'(B[k][j]);
                    s1 = fold(s1, p, W1);
                    s2 = fold(s2, p, W2);
                end
                e.r1[j*W1 +: W1] = s1[W1-1:0];
                e.r2[j*W2 +: W2] = s2[W2-1:0];
            end
            e.idx = RIW'(r);
            q.push_back(e);
        end
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < R; i++)
            a_col[i*AW +: AW] = AW'(A[i][k]);
        for (int j = 0; j < C; j++)
            b_row[j*BW +: BW] = BW'(B[k][j]);
    endtask

    // vmode 0: continuous, 1: toggling, 2: random in_valid
    // omode 0: always ready, 1: 3-cycle stall on row 0, 2: random
    task automatic run_job(input int kk, input int mode, input int vmode,
                           input int omode, input bit lat, input bit poke);
        int k, n, t0;
        bit ph, rdy;
        gen(mode, kk);
        push_expected(kk);
        out_ready = (omode == 0);
        start = 1'b1;
        k_len = KW'(kk);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin
            k_len = KW'(5);
            repeat (2) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        k = 0;
        n = 0;
        ph = 1'b1;
        while (k < kk && n < 500) begin
            unique case (vmode)
                1: begin in_valid = ph; ph = ~ph; end
                2: in_valid = 1'($urandom_range(0, 1));
                default: in_valid = 1'b1;
            endcase
            drive_beat(k);
            rdy = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) k++;
            n++;
        end
        in_valid = 1'b0;
        if (k < kk) begin
            checks++; fails++;
            $display("FAIL feed_timeout: got %0d beats expected %0d", k, kk);
        end
        if (lat || omode == 1) begin
            n = 0;
            while (!out_valid && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            if (lat) check("latency", 128'(cyc - t0), 128'(kk + R + C));
            if (omode == 1) begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        end
        n = 0;
        while (busy && n < 2000) begin
            if (omode == 2) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        if (busy) begin
            checks++; fails++;
            $display("FAIL done_timeout: got busy 1 expected 0");
        end
        @(posedge clk); #1;
        check("busy_after", busy, 1'b0);
        check("drained", 128'(q.size()), 128'(0));
        q.delete();
    endtask

    exp_t prev;
    bit   pstall = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pstall = 1'b0;
        end else begin
            check("ctrl_match", {busy2, in_ready2, out_valid2, ridx2},
                                {busy, in_ready, out_valid, ridx});
            if (out_valid) begin
                if (pstall) begin
                    check("hold_row", out_row, prev.r1);
                    check("hold_idx", ridx, prev.idx);
                end
                if (out_ready) begin
                    if (q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL extra_row: got idx %0d expected none",
                                 ridx);
                    end else begin
                        e = q.pop_front();
                        check("row24", out_row, e.r1);
                        check("row16", out_row2, e.r2);
                        check("row_idx", ridx, e.idx);
                    end
                    pstall = 1'b0;
                end else begin
                    pstall   = 1'b1;
                    prev.r1  = out_row;
                    prev.idx = ridx;
                end
            end else begin
                check("idle_row", {out_row, out_row2}, '0);
                pstall = 1'b0;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k_len     = '0;
        a_col     = '0;
        b_row     = '0;
        #1;
        check("reset_outs", {busy, in_ready, out_valid, ridx, out_row}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_job(4, 1, 0, 0, 1'b1, 1'b0);
        run_job(4, 1, 1, 1, 1'b0, 1'b0);
        run_job(4, 2, 0, 0, 1'b0, 1'b0);
        run_job(2, 2, 0, 0, 1'b1, 1'b0);
        run_job(0, 0, 0, 0, 1'b1, 1'b1);

        // Abort a job mid-feed with an asynchronous reset.
        gen(1, 4);
        start = 1'b1;
        k_len = KW'(4);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        drive_beat(0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_feed_busy", {busy, in_ready}, 2'b11);
        rst = 1'b1;
        #1;
        check("rst_async", {busy, in_ready, out_valid, ridx, out_row}, '0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_job(4, 1, 0, 0, 1'b1, 1'b0);

        for (int t = 0; t < 8; t++)
            run_job(int'($urandom_range(1, 12)), 0, 2, 2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/sysarray_mxn.md
# sysarray_mxn

Parametrised ROWS×COLS output-stationary systolic matrix-multiply engine. It computes C = A·B for an A of ROWS×K and a B of K×COLS, with K set at run time. Unlike the fixed 3×3 array, it owns its own input skew, sequencing, stall and result-drain logic. It takes one A column and one B row per accepted beat and returns C one row per beat over a valid/ready handshake.

## Interface
- ROWS, 4, array rows (≥1)
- COLS, 4, array columns (≥1)
- A_W, 8, signed A element width
- B_W, 8, signed B element width
- ACC_W, 24, signed accumulator width (≥ A_W+B_W)
- K_W, 8, width of k_len
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- k_len  in  K_W  reduction length K; latched on an accepted start
- busy  out  1  high in any state other than IDLE
- in_valid  in  1  input beat present
- in_ready  out  1  high only in FEED
- a_col  in  ROWS*A_W  A[i][k] at bits [i*A_W +: A_W]
- b_row  in  COLS*B_W  B[k][j] at bits [j*B_W +: B_W]
- out_valid  out  1  result row present
- out_ready  in  1  consumer accepts the row
- out_row  out  COLS*ACC_W  C[r][j] at bits [j*ACC_W +: ACC_W]
- out_row_idx  out  max(1,$clog2(ROWS))  r of the current out_row

## Operation
- Reset values: FSM in IDLE; all accumulators, skew registers and PE pipeline registers at 0; busy=0, in_ready=0, out_valid=0, out_row=0, out_row_idx=0.
- IDLE: start=1 latches k_len and moves to CLEAR. start is ignored in every other state.
- CLEAR: one cycle. Zeroes all accumulators and skew/pipe registers. Goes to FEED if K>0, otherwise to FLUSH.
- FEED: each in_valid&in_ready beat is one array step.
  - Row i of A is delayed i steps by a skew shift register; column j of B is delayed j steps.
  - A values move right and B values move down, one PE per step.
  - After K accepted beats the FSM moves to FLUSH.
- Stall: the whole array, including the skew registers, advances only on a step: an accepted beat in FEED, or any FLUSH cycle. With in_valid=0 in FEED nothing changes, so gaps never break alignment.
- FLUSH: ROWS+COLS-2 steps with zero injected at all array edges. The step count is 0 for a 1×1 array, in which case FLUSH goes straight to DRAIN. Then DRAIN.
- PE(i,j) multiply-accumulates element k on step k+i+j: acc += sext(a)·sext(b). The product is a full A_W+B_W-bit signed value, sign-extended to ACC_W. The sum wraps modulo 2^ACC_W unless SYSARRAY_SAT_EN is defined.
- DRAIN:
  - out_valid=1; out_row carries accumulator row r, with r starting at 0.
  - On out_valid&out_ready, r increments.
  - Accepting row ROWS-1 returns the FSM to IDLE.
  - While out_ready=0, out_row and out_row_idx are held stable.
- out_row is 0 outside DRAIN. Accumulators retain their values until the next CLEAR.
- An async rst at any point, including mid-FEED or mid-DRAIN, forces the reset values immediately. The partial job is discarded; the next start runs normally.

## Timing
- start accepted at cycle t: CLEAR at t+1, FEED from t+2.
- With continuous in_valid, FEED spans t+2..t+K+1 and FLUSH spans t+K+2..t+K+ROWS+COLS-1.
- First out_valid at t+K+ROWS+COLS. With continuous out_ready, the last row is at t+K+ROWS+COLS+ROWS-1 and IDLE follows one cycle later.
- in_ready is a registered state decode with no combinational path from in_valid. out_valid does not depend on out_ready.

## Configuration
- SYSARRAY_SAT_EN defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping.
- Undefined: two's-complement wrap. Ports and timing are identical in both builds.

## Test plan
- 4×4, K=4, A=identity, B=1..16 row-major, continuous handshakes: out rows equal B, with first out_valid exactly K+ROWS+COLS cycles after start.
- Same job with in_valid toggling 1,0,1,0 and out_ready low for 3 cycles on row 0: identical results; row 0 held stable while stalled.
- All A=-128, all B=-128, K=4: every C element equals 65536.
- ACC_W=16, A=B=-128, K=2: C=-32768 without SYSARRAY_SAT_EN, 32767 with it.
- k_len=0: CLEAR, FLUSH, then DRAIN of ROWS all-zero rows; start pulsed while busy is ignored.
- rst asserted mid-FEED: all outputs 0 in the same cycle. A following K=4 identity job produces the correct result.
